// File: rtl/gamma_rgb_sequencer.sv
// Time-shares one registered gamma LUT across the R, G and B lanes of a pixel stream.
// Optional GAMMA_BYPASS_EN adds in_bypass, which routes a pixel straight to the output.
module gamma_rgb_sequencer #(
   parameter int unsigned DW      = 8,
   parameter int unsigned LUT_LAT = 1
) (
   input  logic              iCLK,
   input  logic              iRESET,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3*DW-1:0]   in_pixel,
`ifdef GAMMA_BYPASS_EN
   input  logic              in_bypass,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3*DW-1:0]   out_pixel,
   output logic              lut_valid,
   output logic [DW-1:0]     lut_data,
   input  logic [DW-1:0]     lut_result,
   output logic              busy
);
   localparam int unsigned PW   = 3 * DW;
   localparam int unsigned HEAD = LUT_LAT - 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [1:0]              ch_cnt;
   logic [PW-1:0]           hold;
   logic [LUT_LAT-1:0]      tag_vld;
   logic [LUT_LAT-1:0][1:0] tag_ch;
   logic                    accept;
   logic                    b_done;
   logic                    bypass;

`ifdef GAMMA_BYPASS_EN
   assign bypass = in_bypass;
`else
   assign bypass = 1'b0;
`endif

   assign accept = in_valid && in_ready;
   // The B tag reaching the head of the pipe marks the last LUT result of the pixel.
   assign b_done = tag_vld[HEAD] && (tag_ch[HEAD] == 2'd2);

   always_ff @(posedge iCLK) begin
      if (iRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = bypass ? OUT : ISSUE;
         ISSUE:   if (ch_cnt == 2'd2) state_nxt = WAIT;
         WAIT:    if (b_done) state_nxt = OUT;
         OUT:     if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      lut_valid = (state == ISSUE);
      case (ch_cnt)
         2'd0:    lut_data = hold[2*DW +: DW];
         2'd1:    lut_data = hold[DW +: DW];
         default: lut_data = hold[0 +: DW];
      endcase
   end

   // Channel counter, pixel hold, LUT tag pipe and output gathering.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         ch_cnt    <= 2'd0;
         hold      <= '0;
         tag_vld   <= '0;
         tag_ch    <= '0;
         out_valid <= 1'b0;
         out_pixel <= '0;
      end else begin
         out_valid <= (state_nxt == OUT);
         ch_cnt    <= (state == ISSUE) ? 2'(ch_cnt + 2'd1) : 2'd0;
         if (accept) hold <= in_pixel;
         tag_vld[0] <= lut_valid;
         tag_ch[0]  <= ch_cnt;
         for (int i = 1; i < int'(LUT_LAT); i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_ch[i]  <= tag_ch[i-1];
         end
         if (accept && bypass) begin
            out_pixel <= in_pixel;
         end else if (tag_vld[HEAD]) begin
            case (tag_ch[HEAD])
               2'd0:    out_pixel[2*DW +: DW] <= lut_result;
               2'd1:    out_pixel[DW +: DW]   <= lut_result;
               default: out_pixel[0 +: DW]    <= lut_result;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_gamma_rgb_sequencer.sv
// Bench for gamma_rgb_sequencer: vector table, hand sequences and random traffic
// checked against a transaction-level model (pixel in -> LUT-mapped pixel out, in order).
module tb_gamma_rgb_sequencer;
   localparam int unsigned DW = 8;
   localparam int unsigned PW = 3 * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_pixel;
   logic          in_bypass;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_pixel;
   logic          lut_valid;
   logic [DW-1:0] lut_data;
   logic [DW-1:0] lut_result;
   logic          busy;

   logic [DW-1:0] lut_mem [256];
   logic [PW-1:0] exp_q [$];
   int            acc_cyc [$];
   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;

   typedef struct {
      logic [PW-1:0] px;
      logic [PW-1:0] exp;
   } vec_t;
   vec_t vecs [6];

   always #5 clk = ~clk;

   // Registered gamma LUT, one cycle of latency.
   always @(posedge clk) lut_result <= lut_mem[lut_data];

   gamma_rgb_sequencer #(.DW(DW), .LUT_LAT(1)) dut (
      .iCLK       (clk),
      .iRESET     (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pixel   (in_pixel),
`ifdef GAMMA_BYPASS_EN
      .in_bypass  (in_bypass),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_pixel  (out_pixel),
      .lut_valid  (lut_valid),
      .lut_data   (lut_data),
      .lut_result (lut_result),
      .busy       (busy)
   );

   function automatic logic [PW-1:0] gamma_px(input logic [PW-1:0] p);
      return {lut_mem[p[23:16]], lut_mem[p[15:8]], lut_mem[p[7:0]]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: records handshakes seen before the edge and scores transfers against the model.
   task automatic tick();
      logic          acc, xfer, byp;
      logic [PW-1:0] px, op;
      acc  = in_valid && in_ready && !rst;
      xfer = out_valid && out_ready && !rst;
      px   = in_pixel;
      op   = out_pixel;
      byp  = in_bypass;
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (xfer) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL spurious_out: got %0h want no transfer", op);
            end else begin
               logic [PW-1:0] e;
               e = exp_q.pop_front();
               if (op !== e) begin
                  bad++;
                  $display("FAIL out_pixel: got %0h want %0h (cycle %0d)", op, e, cyc);
               end
            end
         end
         if (acc) begin
            exp_q.push_back(byp ? px : gamma_px(px));
            acc_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic wait_out(input int max);
      int n = 0;
      while (!out_valid && n < max) begin
         tick();
         n++;
      end
      check("wait_out_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic drain(input int max);
      int n = 0;
      while (exp_q.size() != 0 && n < max) begin
         tick();
         n++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) lut_mem[i] = 8'((i * i) / 255);
      lut_mem[16] = 8'd4;  lut_mem[128] = 8'd90; lut_mem[255] = 8'd255;
      lut_mem[0]  = 8'd0;  lut_mem[64]  = 8'd32;

      vecs[0] = '{24'h1080FF, 24'h045AFF};
      vecs[1] = '{24'h000000, 24'h000000};
      vecs[2] = '{24'h404040, 24'h202020};
      vecs[3] = '{24'hFFFFFF, 24'hFFFFFF};
      vecs[4] = '{24'h10FF40, 24'h04FF20};
      vecs[5] = '{24'h804000, 24'h5A2000};

      rst = 1'b1; in_valid = 1'b0; in_pixel = '0; in_bypass = 1'b0; out_ready = 1'b0;

      // Reset state
      repeat (3) tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_lut_valid", 32'(lut_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_pixel", 32'(out_pixel), 32'd0);
      check("rst_lut_data", 32'(lut_data), 32'd0);
      rst = 1'b0;
      tick();

      // Vector table: issue order, latency and gathered result per pixel
      out_ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         in_valid = 1'b1;
         in_pixel = vecs[v].px;
         tick();
         in_valid = 1'b0;
         in_pixel = ~vecs[v].px;
         for (int k = 0; k < 3; k++) begin
            check("lut_valid_issue", 32'(lut_valid), 32'd1);
            check("lut_data", 32'(lut_data), 32'(8'(vecs[v].px >> (8 * (2 - k)))));
            tick();
         end
         check("lut_valid_wait", 32'(lut_valid), 32'd0);
         check("out_valid_early", 32'(out_valid), 32'd0);
         tick();
         check("out_valid_e4", 32'(out_valid), 32'd1);
         check("out_pixel_vec", 32'(out_pixel), 32'(vecs[v].exp));
         check("in_ready_out", 32'(in_ready), 32'd0);
         tick();
         check("in_ready_after", 32'(in_ready), 32'd1);
         check("out_valid_after", 32'(out_valid), 32'd0);
      end

      // Backpressure holds OUT
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pixel  = 24'h10FF40;
      tick();
      in_valid = 1'b0;
      wait_out(20);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_pixel", 32'(out_pixel), 32'h04FF20);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);

      // Back-to-back with in_valid held: one accept per 6 cycles
      begin
         logic [PW-1:0] seq [3];
         int k, n;
         seq[0] = 24'h000000; seq[1] = 24'h404040; seq[2] = 24'hFFFFFF;
         acc_cyc.delete();
         k = 0; n = 0;
         in_valid = 1'b1;
         while (k < 3 && n < 40) begin
            in_pixel = seq[k];
            tick();
            if (acc_cyc.size() > k) k++;
            n++;
         end
         in_valid = 1'b0;
         drain(20);
         check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
         if (acc_cyc.size() == 3) begin
            check("b2b_period0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
            check("b2b_period1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
         end
      end

      // Reset while waiting for the B result
      in_valid = 1'b1;
      in_pixel = 24'h1080FF;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_lut_valid", 32'(lut_valid), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_pixel", 32'(out_pixel), 32'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
         end
         check("midrst_no_output", 32'(seen), 32'd0);
      end

`ifdef GAMMA_BYPASS_EN
      // Bypass skips the LUT entirely
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_bypass = 1'b1;
      in_pixel  = 24'h1080FF;
      tick();
      in_valid  = 1'b0;
      in_bypass = 1'b0;
      check("byp_out_valid", 32'(out_valid), 32'd1);
      check("byp_out_pixel", 32'(out_pixel), 32'h1080FF);
      check("byp_lut_valid", 32'(lut_valid), 32'd0);
      out_ready = 1'b1;
      tick();
      check("byp_lut_valid2", 32'(lut_valid), 32'd0);
      check("byp_in_ready", 32'(in_ready), 32'd1);
`endif

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_pixel  = 24'($urandom);
         out_ready = (($urandom % 4) != 0);
`ifdef GAMMA_BYPASS_EN
         in_bypass = 1'($urandom_range(0, 1));
`endif
         tick();
      end
      in_valid  = 1'b0;
      in_bypass = 1'b0;
      out_ready = 1'b1;
      drain(50);
      check("final_idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
